ps2_host_ctrl: RTL

PS2_HOST_CTRL -- requirements
Module: ps2_host_ctrl

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_host_ctrl_if.sv | 23 ++
 rtl/ps2_rx_fifo.sv | 57 +++++
 rtl/ps2_host_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host receive controller.
package ps2_pkg;

  localparam int DATA_W                 = 8;
  localparam int DEFAULT_TIMEOUT_CYCLES = 30000;

  // Receive FSM: waits for a start bit, shifts 8 data bits LSB-first,
  // captures the parity bit, then checks the stop bit.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  // PS/2 uses odd parity: data bits plus parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [DATA_W-1:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_host_ctrl_if.sv
// Read-side port bundle of the PS/2 host controller.
//
// Handshake: the controller holds rd_valid high while the FIFO is non-empty
// and rd_data shows the head byte (8'h00 when empty). A byte is consumed on
// every rising clock edge where rd_valid and rd_ready are both high; rd_data,
// rd_valid and level reflect the pop from the next cycle on. rd_ready while
// rd_valid is low has no effect. level is the current FIFO occupancy.
interface ps2_host_ctrl_if #(
  parameter int FIFO_DEPTH = 8
);
  import ps2_pkg::*;

  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  logic               rd_valid;
  logic               rd_ready;
  logic [DATA_W-1:0]  rd_data;
  logic [LEVEL_W-1:0] level;

  modport master (output rd_valid, output rd_data, output level, input rd_ready);
  modport slave  (input rd_valid, input rd_data, input level, output rd_ready);

endinterface

// File: rtl/ps2_rx_fifo.sv
// Small synchronous FIFO holding received scancodes.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          push,
  input  logic [DATA_W-1:0]             push_data,
  input  logic                          pop,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic [DATA_W-1:0]             head
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign level   = count;
  assign head    = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset because empty masks the head.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ps2_host_ctrl.sv
// PS/2 host receiver: synchronises the device clock/data lines, decodes
// 11-bit frames, queues good scancodes and keeps sticky error flags.
module ps2_host_ctrl
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   ps2_clk,
  input  logic                   ps2_dat,
  input  logic                   clr_err,
  ps2_host_ctrl_if.master        rd,
  output logic                   overflow,
  output logic                   parity_err,
  output logic                   frame_err,
  output ps2_state_e             state_dbg
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [2:0]        clk_sync;
  logic [1:0]        dat_sync;
  logic              sample;
  logic              sbit;

  ps2_state_e        state, state_n;
  logic [2:0]        bit_cnt, bit_cnt_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic              par_q, par_n;
  logic [TW-1:0]     tmo_cnt, tmo_n;
  logic              push_n, push_q;
  logic [DATA_W-1:0] push_data_q;
  logic              perr_ev, ferr_ev, ovf_ev;

  logic              fifo_full, fifo_empty;

  // Falling edge of the synchronised PS/2 clock marks a bit to sample.
  assign sample    = clk_sync[2] & ~clk_sync[1];
  assign sbit      = dat_sync[1];
  assign state_dbg = state;

  // Two/three-flop synchronisers; reset to the idle-high line level.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_sync <= 3'b111;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[1:0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
    end
  end

  // Frame decoder state and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      par_q       <= 1'b0;
      tmo_cnt     <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
    end else begin
      state       <= state_n;
      bit_cnt     <= bit_cnt_n;
      shreg       <= shreg_n;
      par_q       <= par_n;
      tmo_cnt     <= tmo_n;
      push_q      <= push_n;
      push_data_q <= shreg;
    end
  end

  // Next-state logic: advances only on sample events, except the timeout
  // that abandons a stalled partial frame.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    par_n     = par_q;
    tmo_n     = tmo_cnt;
    push_n    = 1'b0;
    perr_ev   = 1'b0;
    ferr_ev   = 1'b0;
    if (state == IDLE) begin
      tmo_n = '0;
      if (sample && !sbit) begin
        state_n   = DATA;
        bit_cnt_n = '0;
        shreg_n   = '0;
      end
    end else if (sample) begin
      tmo_n = '0;
      case (state)
        DATA: begin
          shreg_n = {sbit, shreg[DATA_W-1:1]};
          if (bit_cnt == 3'd7) state_n = PARITY;
          else                 bit_cnt_n = bit_cnt + 3'd1;
        end
        PARITY: begin
          par_n   = sbit;
          state_n = STOP;
        end
        STOP: begin
          state_n = IDLE;
          if (!sbit)                          ferr_ev = 1'b1;
          else if (odd_parity_ok(shreg, par_q)) push_n  = 1'b1;
          else                                perr_ev = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
      state_n = IDLE;
      ferr_ev = 1'b1;
      tmo_n   = '0;
    end else begin
      tmo_n = tmo_cnt + TW'(1);
    end
  end

  // A full FIFO never pushes unless the consumer pops in the same cycle.
  assign ovf_ev = push_q & fifo_full & ~rd.rd_ready;

  ps2_rx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_q),
    .push_data (push_data_q),
    .pop       (rd.rd_ready),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (rd.level),
    .head      (rd.rd_data)
  );

  assign rd.rd_valid = ~fifo_empty;

  // Sticky error flags; a new error event wins over a same-cycle clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      overflow   <= (overflow   & ~clr_err) | ovf_ev;
      parity_err <= (parity_err & ~clr_err) | perr_ev;
      frame_err  <= (frame_err  & ~clr_err) | ferr_ev;
    end
  end

endmodule
